vga_pixel_timing_out: RTL and testbench

- Downstream/upstream neighbour of the object priority mux.
- Generates 640x480@60 raster counters (pixelX/pixelY) that all drawing blocks and the mux consume.
- Takes the mux's registered 24-bit colour back and drives the VGA DAC pins.
- Delays sync/blank by the mux pipeline latency so colour and sync stay pixel-aligned, and blanks colour outside the active area.

---
 rtl/vga_pixel_timing_out_if.sv | 32 +++
 rtl/vga_pixel_timing_out.sv | 196 +++++++++++++++++++
 tb/tb_vga_pixel_timing_out.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/vga_pixel_timing_out_if.sv
// Pixel-clock bundle between the object mux and the VGA raster/DAC output block.
// The slave side generates the raster and drives the DAC pins; the master side supplies colour.
interface vga_pixel_timing_out_if;
  logic [7:0]  redIn;
  logic [7:0]  greenIn;
  logic [7:0]  blueIn;
  logic        fadeStart;
  logic        fadeClear;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        startOfFrame;
  logic [7:0]  vgaR;
  logic [7:0]  vgaG;
  logic [7:0]  vgaB;
  logic        vgaHS;
  logic        vgaVS;
  logic        vgaBlankN;
  logic [15:0] frameCount;
  logic [2:0]  fadeLevel;

  modport master (
    output redIn, greenIn, blueIn, fadeStart, fadeClear,
    input  pixelX, pixelY, startOfFrame, vgaR, vgaG, vgaB,
    input  vgaHS, vgaVS, vgaBlankN, frameCount, fadeLevel
  );

  modport slave (
    input  redIn, greenIn, blueIn, fadeStart, fadeClear,
    output pixelX, pixelY, startOfFrame, vgaR, vgaG, vgaB,
    output vgaHS, vgaVS, vgaBlankN, frameCount, fadeLevel
  );
endinterface

// File: rtl/vga_pixel_timing_out.sv
// 640x480@60 raster counters plus DAC output stage; sync/blank/colour for a pixel appear PIPE_LAT+1
// clocks after its pixelX/pixelY, no backpressure. Optional per-frame fade-out enabled by macro FADE_EN.
module vga_pixel_timing_out #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int PIPE_LAT    = 1,
  parameter int FADE_FRAMES = 4
) (
  input logic                  clk,
  input logic                  resetN,
  vga_pixel_timing_out_if.slave bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  typedef struct packed {
    logic act;
    logic hs_n;
    logic vs_n;
  } raw_t;

  localparam raw_t RAW_RST = '{act: 1'b0, hs_n: 1'b1, vs_n: 1'b1};

  logic [10:0] h_q, h_d, v_q, v_d;
  logic        sof_q, sof_d;
  logic [15:0] frm_q, frm_d;
  logic        eol, eof;
  raw_t        raw, dly;
  logic [2:0]  lvl;
  logic [7:0]  r_q, r_d, g_q, g_d, b_q, b_d;
  logic        hs_q, vs_q, bn_q;

  // Raster counters; startOfFrame is precomputed so it is high while the counters read (0,0)
  always_comb begin
    eol   = (h_q == H_LAST);
    eof   = eol && (v_q == V_LAST);
    h_d   = eol ? 11'd0 : h_q + 11'd1;
    v_d   = v_q;
    if (eol) v_d = (v_q == V_LAST) ? 11'd0 : v_q + 11'd1;
    sof_d = eof;
    frm_d = eof ? frm_q + 16'd1 : frm_q;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      h_q   <= '0;
      v_q   <= '0;
      sof_q <= 1'b0;
      frm_q <= '0;
    end else begin
      h_q   <= h_d;
      v_q   <= v_d;
      sof_q <= sof_d;
      frm_q <= frm_d;
    end
  end

  always_comb begin
    raw.act  = (h_q < H_ACT) && (v_q < V_ACT);
    raw.hs_n = !((h_q >= HS_BEG) && (h_q < HS_END));
    raw.vs_n = !((v_q >= VS_BEG) && (v_q < VS_END));
  end

  // Match the mux pipeline so sync/blank line up with the colour that arrives for the same pixel
  if (PIPE_LAT == 0) begin : g_nopipe
    assign dly = raw;
  end else begin : g_pipe
    raw_t pipe_q [PIPE_LAT];

    always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
        for (int i = 0; i < PIPE_LAT; i++) pipe_q[i] <= RAW_RST;
      end else begin
        pipe_q[0] <= raw;
        for (int i = 1; i < PIPE_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign dly = pipe_q[PIPE_LAT-1];
  end

`ifdef FADE_EN
  typedef enum logic [1:0] {F_IDLE, F_FADING, F_HELD} fade_st_t;

  localparam logic [7:0] SUB_LAST = 8'(FADE_FRAMES - 1);

  fade_st_t   st_q, st_d;
  logic [7:0] sub_q, sub_d;
  logic [2:0] lvl_q, lvl_d;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      st_q  <= F_IDLE;
      sub_q <= '0;
      lvl_q <= '0;
    end else begin
      st_q  <= st_d;
      sub_q <= sub_d;
      lvl_q <= lvl_d;
    end
  end

  // Steps only on startOfFrame so the shift stays constant across a whole frame
  always_comb begin
    st_d  = st_q;
    sub_d = sub_q;
    lvl_d = lvl_q;
    if (bus.fadeClear) begin
      st_d  = F_IDLE;
      sub_d = '0;
      lvl_d = '0;
    end else begin
      case (st_q)
        F_IDLE: begin
          if (bus.fadeStart) begin
            st_d  = F_FADING;
            sub_d = '0;
          end
        end
        F_FADING: begin
          if (sof_q) begin
            if (sub_q == SUB_LAST) begin
              sub_d = '0;
              lvl_d = lvl_q + 3'd1;
              if (lvl_q == 3'd6) st_d = F_HELD;
            end else begin
              sub_d = sub_q + 8'd1;
            end
          end
        end
        F_HELD:  st_d = F_HELD;
        default: st_d = F_IDLE;
      endcase
    end
  end

  assign lvl = lvl_q;
`else
  logic unused_fade;
  assign unused_fade = &{1'b0, bus.fadeStart, bus.fadeClear};
  assign lvl = 3'd0;
`endif

  always_comb begin
    r_d = dly.act ? (bus.redIn   >> lvl) : 8'h00;
    g_d = dly.act ? (bus.greenIn >> lvl) : 8'h00;
    b_d = dly.act ? (bus.blueIn  >> lvl) : 8'h00;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      bn_q <= 1'b0;
    end else begin
      r_q  <= r_d;
      g_q  <= g_d;
      b_q  <= b_d;
      hs_q <= dly.hs_n;
      vs_q <= dly.vs_n;
      bn_q <= dly.act;
    end
  end

  assign bus.pixelX       = h_q;
  assign bus.pixelY       = v_q;
  assign bus.startOfFrame = sof_q;
  assign bus.frameCount   = frm_q;
  assign bus.fadeLevel    = lvl;
  assign bus.vgaR         = r_q;
  assign bus.vgaG         = g_q;
  assign bus.vgaB         = b_q;
  assign bus.vgaHS        = hs_q;
  assign bus.vgaVS        = vs_q;
  assign bus.vgaBlankN    = bn_q;

endmodule

// File: tb/tb_vga_pixel_timing_out.sv
// Directed bench on a scaled-down raster (32x19 total) so whole frames fit in a short run.
module tb_vga_pixel_timing_out;
  localparam int HA = 16, HFP = 4, HSW = 8, HBP = 4;
  localparam int VA = 12, VFP = 2, VSW = 2, VBP = 3;
  localparam int PL = 1, FFR = 2;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;
`ifdef FADE_EN
  localparam bit FADE_ON = 1'b1;
`else
  localparam bit FADE_ON = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       hs;
    logic       vs;
    logic       bn;
  } pix_t;

  localparam pix_t PIX_RST = '{r: 8'h00, g: 8'h00, b: 8'h00, hs: 1'b1, vs: 1'b1, bn: 1'b0};

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  vga_pixel_timing_out_if vif();

  vga_pixel_timing_out #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .PIPE_LAT(PL), .FADE_FRAMES(FFR)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .bus(vif)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Scoreboard of expected DAC outputs, one entry per pixel clock
  pix_t sbq[$];

  int         hx, vy, fst, sub;
  logic [15:0] fcnt;
  logic [2:0] lvl;
  bit         sof_e;
  bit         const_ff;
  logic [7:0] pr, pg, pb;
  int         bn_cnt, hs_lo, vs_lo, ff_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    hx = 0; vy = 0; fst = 0; sub = 0;
    fcnt = '0; lvl = '0; sof_e = 1'b0;
    pr = '0; pg = '0; pb = '0;
    bn_cnt = 0; hs_lo = 0; vs_lo = 0; ff_cnt = 0;
    sbq.delete();
    repeat (PL + 1) sbq.push_back(PIX_RST);
  endtask

  task automatic rst_chk(input string tag);
    pix_t o;
    o = '{r: vif.vgaR, g: vif.vgaG, b: vif.vgaB, hs: vif.vgaHS, vs: vif.vgaVS, bn: vif.vgaBlankN};
    chk({tag, "_pix"}, 64'(o), 64'(PIX_RST));
    chk({tag, "_ctr"}, 64'({vif.pixelX, vif.pixelY, vif.startOfFrame, vif.frameCount, vif.fadeLevel}), 64'd0);
  endtask

  // Check the current cycle, drive this cycle's inputs, advance the model, move to the next cycle
  task automatic step(input bit fs = 1'b0, input bit fcl = 1'b0);
    pix_t       o, e;
    bit         act, hsn, vsn;
    logic [7:0] cr, cg, cb;
    logic [2:0] lvl_n;
    o = '{r: vif.vgaR, g: vif.vgaG, b: vif.vgaB, hs: vif.vgaHS, vs: vif.vgaVS, bn: vif.vgaBlankN};
    e = sbq.pop_front();
    chk("pix", 64'(o), 64'(e));
    chk("ctr", 64'({vif.pixelX, vif.pixelY, vif.startOfFrame, vif.frameCount, vif.fadeLevel}),
               64'({11'(hx), 11'(vy), sof_e, fcnt, lvl}));
    if (o.bn === 1'b1) bn_cnt++;
    if (o.hs === 1'b0) hs_lo++;
    if (o.vs === 1'b0) vs_lo++;
    if (o.r === 8'hFF) ff_cnt++;

    vif.redIn = pr; vif.greenIn = pg; vif.blueIn = pb;
    vif.fadeStart = fs; vif.fadeClear = fcl;

    act = (hx < HA) && (vy < VA);
    hsn = !((hx >= HA + HFP) && (hx < HA + HFP + HSW));
    vsn = !((vy >= VA + VFP) && (vy < VA + VFP + VSW));
    cr = const_ff ? 8'hFF : 8'(hx);
    cg = const_ff ? 8'hFF : 8'(vy);
    cb = const_ff ? 8'hFF : 8'h5A;

    lvl_n = lvl;
    if (FADE_ON) begin
      if (fcl) begin
        fst = 0; sub = 0; lvl_n = 3'd0;
      end else if (fst == 0) begin
        if (fs) begin fst = 1; sub = 0; end
      end else if (fst == 1 && sof_e) begin
        if (sub == FFR - 1) begin
          sub = 0;
          lvl_n = 3'(lvl + 3'd1);
          if (lvl_n == 3'd7) fst = 2;
        end else begin
          sub++;
        end
      end
    end
    sbq.push_back('{r: act ? (cr >> lvl_n) : 8'h00, g: act ? (cg >> lvl_n) : 8'h00,
                    b: act ? (cb >> lvl_n) : 8'h00, hs: hsn, vs: vsn, bn: act});

    sof_e = (hx == HT - 1) && (vy == VT - 1);
    if (sof_e) fcnt++;
    if (hx == HT - 1) begin
      hx = 0;
      vy = (vy == VT - 1) ? 0 : vy + 1;
    end else begin
      hx++;
    end
    lvl = lvl_n;
    pr = cr; pg = cg; pb = cb;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    vif.redIn = '0; vif.greenIn = '0; vif.blueIn = '0;
    vif.fadeStart = 1'b0; vif.fadeClear = 1'b0;
    const_ff = 1'b0;
    resetN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_chk("por");
    resetN = 1'b1;
    model_reset();

    // Two full frames of the {x, y, 5A} mux pattern: frameCount 0 -> 1 -> 2
    repeat (2 * FRAME + 5) step();

    // Horizontal sync placement and line period
    for (int i = 0; i < 2 * HT && hx != 0; i++) step();
    n = 0;
    while (n < 2 * HT && vif.vgaHS !== 1'b0) begin step(); n++; end
    chk("hs_offset", 64'(n), 64'(HA + HFP + PL + 1));
    n = 0;
    while (n < 2 * HT && vif.vgaHS === 1'b0) begin step(); n++; end
    chk("hs_width", 64'(n), 64'(HSW));
    n = 0;
    while (n < 2 * HT && vif.vgaHS !== 1'b0) begin step(); n++; end
    chk("hs_gap", 64'(n), 64'(HT - HSW));

    // Colour alignment at the start of an active line
    n = 0;
    while (n < 2 * FRAME && vif.vgaBlankN !== 1'b1) begin step(); n++; end
    chk("blank_rise_seen", 64'(vif.vgaBlankN), 64'd1);
    chk("rise_r", 64'(vif.vgaR), 64'h00);
    chk("rise_g", 64'(vif.vgaG), 64'(vy - ((hx < PL + 1) ? 1 : 0)));
    repeat (9) step();
    chk("act10_r", 64'(vif.vgaR), 64'h09);

    // One frame-length window of pattern mode
    bn_cnt = 0; hs_lo = 0; vs_lo = 0;
    repeat (FRAME) step();
    chk("act_cycles", 64'(bn_cnt), 64'(HA * VA));
    chk("vs_low", 64'(vs_lo), 64'(VSW * HT));
    chk("hs_low", 64'(hs_lo), 64'(HSW * VT));

    // Reset asserted mid-line
    for (int i = 0; i < 2 * HT && hx != 20; i++) step();
    resetN = 1'b0;
    #1;
    rst_chk("mid");
    @(posedge clk);
    #1;
    rst_chk("mid_hold");
    resetN = 1'b1;
    model_reset();

    // Constant white: only the active area may show 0xFF
    const_ff = 1'b1;
    repeat (FRAME) step();
    chk("ff_cycles", 64'(ff_cnt), 64'(HA * VA));

    // Fade sequence (shift stays 0 when the fade is not built)
    repeat (100) step();
    step(1'b1, 1'b0);
    repeat (16 * FRAME) step();
    chk("fade_sat", 64'(vif.fadeLevel), 64'(FADE_ON ? 7 : 0));
    step(1'b0, 1'b1);
    chk("fade_clr", 64'(vif.fadeLevel), 64'd0);
    repeat (FRAME) step();
    step(1'b1, 1'b0);
    repeat (3 * FRAME) step();
    step(1'b1, 1'b1);
    chk("fade_both", 64'(vif.fadeLevel), 64'd0);
    repeat (FRAME + 10) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
